// File: rtl/pipe_controller_rv32i.sv
// Pipelined RV32I control unit: decodes in D and carries control through the E, M and W registers.
// It also produces the branch/jump redirect, an illegal-instruction flag and a retired-instruction count.
module pipe_controller_rv32i #(
   parameter int ALUCTRL_W = 4,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opD,
   input  logic [2:0]           funct3D,
   input  logic                 funct7b5D,
   output logic [2:0]           ImmSrcD,
   output logic                 IllegalD,
   input  logic                 StallE,
   input  logic                 FlushE,
   input  logic                 ZeroE,
   input  logic                 LtE,
   input  logic                 LtuE,
   output logic                 PCSrcE,
   output logic                 PCTargetSrcE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic [1:0]           ALUSrcAE,
   output logic                 ALUSrcBE,
   output logic                 ResultSrcEb0,
   output logic                 MemWriteM,
   output logic [2:0]           Funct3M,
   output logic                 RegWriteM,
   output logic                 RegWriteW,
   output logic [1:0]           ResultSrcW,
   output logic                 ValidW,
   output logic [CNT_W-1:0]     InstRetCount
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic       branch;
      logic       jump;
      logic [1:0] aluSrcA;
      logic       aluSrcB;
      logic       pcTargetSrc;
      logic [3:0] aluCode;
      logic [2:0] funct3;
   } ctrlE_t;

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic [2:0] funct3;
   } ctrlM_t;

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [1:0] resultSrc;
   } ctrlW_t;

   ctrlE_t           ctrlD;
   ctrlE_t           ctrlE;
   ctrlM_t           ctrlM;
   ctrlW_t           ctrlW;
   logic [3:0]       aluFunct;
   logic [2:0]       immSrc;
   logic             illegal;
   logic             branchTaken;
   logic [CNT_W-1:0] retCount;

   // funct3 selects the ALU op; funct7b5 only means sub for R-type, but always means sra
   always_comb begin
      aluFunct = ALU_ADD;
      case (funct3D)
         3'b000: aluFunct = (opD == OP_R && funct7b5D) ? ALU_SUB : ALU_ADD;
         3'b001: aluFunct = ALU_SLL;
         3'b010: aluFunct = ALU_SLT;
         3'b011: aluFunct = ALU_SLTU;
         3'b100: aluFunct = ALU_XOR;
         3'b101: aluFunct = funct7b5D ? ALU_SRA : ALU_SRL;
         3'b110: aluFunct = ALU_OR;
         3'b111: aluFunct = ALU_AND;
      endcase
   end

   always_comb begin
      ctrlD   = '0;
      immSrc  = IMM_I;
      illegal = 1'b0;
      case (opD)
         OP_LOAD: begin
            ctrlD.regWrite  = 1'b1;
            ctrlD.aluSrcB   = 1'b1;
            ctrlD.resultSrc = 2'b01;
            immSrc          = IMM_I;
         end
         OP_STORE: begin
            ctrlD.memWrite = 1'b1;
            ctrlD.aluSrcB  = 1'b1;
            immSrc         = IMM_S;
         end
         OP_R: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluCode  = aluFunct;
         end
         OP_I: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluSrcB  = 1'b1;
            ctrlD.aluCode  = aluFunct;
            immSrc         = IMM_I;
         end
         OP_BRANCH: begin
            illegal        = (funct3D[2:1] == 2'b01);
            ctrlD.branch   = 1'b1;
            ctrlD.aluCode  = ALU_SUB;
            immSrc         = IMM_B;
         end
         OP_JAL: begin
            ctrlD.regWrite  = 1'b1;
            ctrlD.jump      = 1'b1;
            ctrlD.resultSrc = 2'b10;
            immSrc          = IMM_J;
         end
         OP_JALR: begin
            illegal           = (funct3D != 3'b000);
            ctrlD.regWrite    = 1'b1;
            ctrlD.jump        = 1'b1;
            ctrlD.aluSrcB     = 1'b1;
            ctrlD.pcTargetSrc = 1'b1;
            ctrlD.resultSrc   = 2'b10;
            immSrc            = IMM_I;
         end
         OP_LUI: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluSrcA  = 2'b10;
            ctrlD.aluSrcB  = 1'b1;
            immSrc         = IMM_U;
         end
         OP_AUIPC: begin
            ctrlD.regWrite = 1'b1;
            ctrlD.aluSrcA  = 2'b01;
            ctrlD.aluSrcB  = 1'b1;
            immSrc         = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
      ctrlD.valid  = ~illegal;
      ctrlD.funct3 = funct3D;
      // An illegal encoding travels as a plain bubble
      if (illegal) begin
         ctrlD  = '0;
         immSrc = IMM_I;
      end
   end

   assign ImmSrcD  = immSrc;
   assign IllegalD = illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlE <= '0;
      end else if (FlushE) begin
         ctrlE <= '0;
      end else if (!StallE) begin
         ctrlE <= ctrlD;
      end
   end

   // While E is held, M takes a bubble so the held instruction is not issued twice
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlM <= '0;
      end else if (StallE && !FlushE) begin
         ctrlM <= '0;
      end else begin
         ctrlM <= {ctrlE.valid, ctrlE.regWrite, ctrlE.resultSrc, ctrlE.memWrite, ctrlE.funct3};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlW    <= '0;
         retCount <= '0;
      end else begin
         ctrlW <= {ctrlM.valid, ctrlM.regWrite, ctrlM.resultSrc};
         if (ctrlW.valid) begin
            retCount <= retCount + CNT_W'(1);
         end
      end
   end

   always_comb begin
      branchTaken = 1'b0;
      case (ctrlE.funct3)
         3'b000:  branchTaken = ZeroE;
         3'b001:  branchTaken = ~ZeroE;
         3'b100:  branchTaken = LtE;
         3'b101:  branchTaken = ~LtE;
         3'b110:  branchTaken = LtuE;
         3'b111:  branchTaken = ~LtuE;
         default: branchTaken = 1'b0;
      endcase
   end

   assign PCSrcE       = ctrlE.valid & (ctrlE.jump | (ctrlE.branch & branchTaken));
   assign PCTargetSrcE = ctrlE.pcTargetSrc;
   assign ALUControlE  = ALUCTRL_W'(ctrlE.aluCode);
   assign ALUSrcAE     = ctrlE.aluSrcA;
   assign ALUSrcBE     = ctrlE.aluSrcB;
   assign ResultSrcEb0 = ctrlE.resultSrc[0];
   assign MemWriteM    = ctrlM.memWrite;
   assign Funct3M      = ctrlM.funct3;
   assign RegWriteM    = ctrlM.regWrite;
   assign RegWriteW    = ctrlW.regWrite;
   assign ResultSrcW   = ctrlW.resultSrc;
   assign ValidW       = ctrlW.valid;
   assign InstRetCount = retCount;

endmodule

// File: tb/tb_pipe_controller_rv32i.sv
// Randomised bench for pipe_controller_rv32i: instruction-level model with a retirement scoreboard.
// Stimulus checks D/E/M outputs mid-cycle; a monitor pops retirements at W and tracks the counter.
module tb_pipe_controller_rv32i;

   localparam int ALUCTRL_W = 4;
   localparam int CNT_W     = 4;
   localparam logic [31:0] ALU_TAB = {4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7, 4'd0};

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic       branch;
      logic       jump;
      logic [1:0] srcA;
      logic       srcB;
      logic       pcTgt;
      logic [3:0] alu;
      logic [2:0] imm;
      logic [2:0] funct3;
   } rec_t;

   logic                 clk;
   logic                 reset;
   logic [6:0]           opD;
   logic [2:0]           funct3D;
   logic                 funct7b5D;
   logic [2:0]           ImmSrcD;
   logic                 IllegalD;
   logic                 StallE, FlushE, ZeroE, LtE, LtuE;
   logic                 PCSrcE, PCTargetSrcE;
   logic [ALUCTRL_W-1:0] ALUControlE;
   logic [1:0]           ALUSrcAE;
   logic                 ALUSrcBE, ResultSrcEb0;
   logic                 MemWriteM;
   logic [2:0]           Funct3M;
   logic                 RegWriteM, RegWriteW;
   logic [1:0]           ResultSrcW;
   logic                 ValidW;
   logic [CNT_W-1:0]     InstRetCount;

   int   checks = 0;
   int   errors = 0;
   int   expCount = 0;
   int   retired = 0;
   rec_t eSlot = '0;
   rec_t mSlot = '0;
   rec_t wQ[$];

   pipe_controller_rv32i #(.ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
      .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .StallE(StallE), .FlushE(FlushE),
      .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE),
      .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
      .ResultSrcEb0(ResultSrcEb0), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ValidW(ValidW), .InstRetCount(InstRetCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // What each instruction should do, straight from the decode table
   function automatic rec_t refDecode(logic [6:0] op, logic [2:0] f3, logic f7);
      rec_t r;
      logic [3:0] fn;
      r = '0;
      r.valid = 1'b1;
      fn = ALU_TAB[int'(f3)*4 +: 4];
      if (f3 == 3'd5 && f7) fn = 4'd9;
      case (op)
         7'b0000011: begin r.regWrite = 1; r.srcB = 1; r.resultSrc = 2'b01; r.imm = 3'd0; end
         7'b0100011: begin r.memWrite = 1; r.srcB = 1; r.imm = 3'd1; end
         7'b0110011: begin r.regWrite = 1; r.alu = (f3 == 3'd0 && f7) ? 4'd1 : fn; end
         7'b0010011: begin r.regWrite = 1; r.srcB = 1; r.alu = fn; end
         7'b1100011: begin r.branch = 1; r.imm = 3'd2; r.alu = 4'd1; if (f3 == 3'd2 || f3 == 3'd3) r.valid = 0; end
         7'b1101111: begin r.regWrite = 1; r.jump = 1; r.imm = 3'd3; r.resultSrc = 2'b10; end
         7'b1100111: begin
            r.regWrite = 1; r.jump = 1; r.srcB = 1; r.pcTgt = 1; r.resultSrc = 2'b10;
            if (f3 != 3'd0) r.valid = 0;
         end
         7'b0110111: begin r.regWrite = 1; r.imm = 3'd4; r.srcA = 2'b10; r.srcB = 1; end
         7'b0010111: begin r.regWrite = 1; r.imm = 3'd4; r.srcA = 2'b01; r.srcB = 1; end
         default: r.valid = 1'b0;
      endcase
      r.funct3 = f3;
      if (!r.valid) r = '0;
      return r;
   endfunction

   function automatic logic refTaken(logic [2:0] f3, logic z, logic l, logic lu);
      logic c;
      case (f3[2:1])
         2'b00:   c = z;
         2'b10:   c = l;
         2'b11:   c = lu;
         default: c = 1'b0;
      endcase
      return c ^ f3[0];
   endfunction

   // One cycle: drive at negedge, check D/E/M mid-cycle, then advance the model past the coming edge
   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic st, input logic fl, input logic z, input logic l, input logic lu);
      rec_t r;
      @(negedge clk);
      opD = op; funct3D = f3; funct7b5D = f7;
      StallE = st; FlushE = fl; ZeroE = z; LtE = l; LtuE = lu;
      #1;
      r = refDecode(op, f3, f7);
      chk("IllegalD", {31'd0, IllegalD}, {31'd0, ~r.valid});
      chk("ImmSrcD", {29'd0, ImmSrcD}, {29'd0, r.imm});
      chk("PCSrcE", {31'd0, PCSrcE},
          {31'd0, eSlot.valid & (eSlot.jump | (eSlot.branch & refTaken(eSlot.funct3, z, l, lu)))});
      chk("PCTargetSrcE", {31'd0, PCTargetSrcE}, {31'd0, eSlot.pcTgt});
      chk("ALUControlE", 32'(ALUControlE), {28'd0, eSlot.alu});
      chk("ALUSrcAE", {30'd0, ALUSrcAE}, {30'd0, eSlot.srcA});
      chk("ALUSrcBE", {31'd0, ALUSrcBE}, {31'd0, eSlot.srcB});
      chk("ResultSrcEb0", {31'd0, ResultSrcEb0}, {31'd0, eSlot.resultSrc[0]});
      chk("MemWriteM", {31'd0, MemWriteM}, {31'd0, mSlot.memWrite});
      chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, mSlot.regWrite});
      if (mSlot.valid) chk("Funct3M", {29'd0, Funct3M}, {29'd0, mSlot.funct3});
      if (fl || !st) begin
         mSlot = eSlot;
         if (eSlot.valid) wQ.push_back(eSlot);
      end else begin
         mSlot = '0;
      end
      if (fl) eSlot = '0;
      else if (!st) eSlot = r;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      opD = 7'd0; funct3D = 3'd0; funct7b5D = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      #1;
      chk("rst_ValidW", {31'd0, ValidW}, 32'd0);
      chk("rst_InstRetCount", 32'(InstRetCount), 32'd0);
      chk("rst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
      chk("rst_MemWriteM", {31'd0, MemWriteM}, 32'd0);
      chk("rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
      chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("rst_ALUControlE", 32'(ALUControlE), 32'd0);
      eSlot = '0;
      mSlot = '0;
      wQ.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [6:0] pickOp();
      case ($urandom_range(0, 10))
         0: return 7'b0000011;
         1: return 7'b0100011;
         2: return 7'b0110011;
         3: return 7'b0010011;
         4: return 7'b1100011;
         5: return 7'b1101111;
         6: return 7'b1100111;
         7: return 7'b0110111;
         8: return 7'b0010111;
         9: return 7'($urandom);
         default: return 7'b0001111;
      endcase
   endfunction

   // Monitor: counter follows retirements; each ValidW pops the oldest expected retirement
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            expCount = 0;
         end else begin
            chk("InstRetCount", 32'(InstRetCount), expCount & ((1 << CNT_W) - 1));
            if (ValidW) begin
               if (wQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL W_unexpected: ValidW=1 with no instruction expected at %0t", $time);
               end else begin
                  rec_t e;
                  e = wQ.pop_front();
                  retired++;
                  $display("retire %0d: RegWriteW=%0b ResultSrcW=%0b count=%0d", retired, RegWriteW, ResultSrcW, InstRetCount);
                  chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.regWrite});
                  chk("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, e.resultSrc});
               end
               expCount++;
            end else begin
               chk("RegWriteW_bubble", {31'd0, RegWriteW}, 32'd0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [2:0] brF3 [7];
      brF3 = '{3'd1, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd2};
      reset = 1'b0;
      opD = 7'd0; funct3D = 3'd0; funct7b5D = 1'b0;
      StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
      #1;
      chk("init_ValidW", {31'd0, ValidW}, 32'd0);
      chk("init_InstRetCount", 32'(InstRetCount), 32'd0);
      chk("init_PCSrcE", {31'd0, PCSrcE}, 32'd0);
      chk("init_MemWriteM", {31'd0, MemWriteM}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // R-type sub through the whole pipe
      step(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop(5);
      chk("sub_retired_count", 32'(InstRetCount), 32'd1);

      // Branch conditions with all flags clear
      for (int i = 0; i < 7; i++) begin
         step(7'b1100011, brF3[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         nop(1);
      end

      // JALR then LUI
      step(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(7'b0110111, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop(4);

      // Store held in E for two cycles
      step(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nop(4);

      // JAL flushed while stalled: never executes
      step(7'b1101111, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      nop(4);

      // 17 ADDIs from reset wrap the 4-bit counter to 1
      doReset();
      for (int i = 0; i < 17; i++) step(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nop(5);
      chk("wrap_count", 32'(InstRetCount), 32'd1);

      // Random traffic with a reset in the middle of a burst
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            for (int i = 0; i < 6; i++) step(7'b0010011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            doReset();
         end
         step(pickOp(), 3'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      nop(6);
      chk("queue_drained", wQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
